// File: rtl/turbosim_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | turbosim_pkg: record field layout, net value codes, drain states  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package turbosim_pkg;

  localparam int REC_VAL_MSB  = 31;
  localparam int REC_VAL_LSB  = 30;
  localparam int REC_IDX_MSB  = 29;
  localparam int REC_IDX_LSB  = 16;
  localparam int REC_TIME_MSB = 15;
  localparam int REC_TIME_LSB = 0;

  localparam logic [1:0] VAL_0 = 2'b00;
  localparam logic [1:0] VAL_1 = 2'b01;
  localparam logic [1:0] VAL_X = 2'b10;
  localparam logic [1:0] VAL_Z = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/drain_shadow_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | drain_shadow_ram: 1W1R synchronous RAM with write-through read    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module drain_shadow_ram #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // A same-cycle write to the read address is returned instead of the stale entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= (we && (waddr == raddr)) ? wdata : r_mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/turbosim_event_drain.sv
`default_nettype none
// +------------------------------------------------------------------+
// | turbosim_event_drain: drains turbosim output records, keeps a     |
// | shadow of net values, counts changes and flags order/range errors.|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module turbosim_event_drain
  import turbosim_pkg::*;
#(
  parameter int NET_IDX_W = 14,
  parameter int TIME_W    = 16,
  parameter int NET_DEPTH = 512,
  parameter int CNT_W     = 16,
  parameter int FLUSH_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 empty,
  input  logic [31:0]          out_record,
  output logic                 rd,
  input  logic                 go,
  input  logic                 done,
  input  logic                 host_rd_en,
  input  logic [NET_IDX_W-1:0] host_rd_addr,
  output logic [1:0]           host_rd_data,
  output logic [CNT_W-1:0]     change_count,
  output logic [TIME_W-1:0]    last_time,
  output logic                 iter_done,
  output logic                 busy,
  output logic                 err_order,
  output logic                 err_range,
  output logic                 err_stray
);

  localparam int ADDR_W = $clog2(NET_DEPTH);
  localparam int RUN_W  = $clog2(FLUSH_CYC + 1);

  drain_state_t          r_state, w_next_state;
  logic [ADDR_W-1:0]     r_init_addr;
  logic                  r_go_pend;
  logic [RUN_W-1:0]      r_run;
  logic                  r_s1_valid;
  logic [1:0]            r_s1_val;
  logic [NET_IDX_W-1:0]  r_s1_idx;
  logic [TIME_W-1:0]     r_s1_time;
  logic                  r_first;
  logic [CNT_W-1:0]      r_change_count;
  logic [TIME_W-1:0]     r_last_time;
  logic                  r_iter_done, r_err_order, r_err_range, r_err_stray;
  logic                  r_rd_oor;
  logic                  w_restart, w_close, w_s1_in_range, w_host_oor;
  logic                  w_ram_we;
  logic [ADDR_W-1:0]     w_ram_waddr;
  logic [1:0]            w_ram_wdata, w_ram_rdata;

  assign w_s1_in_range = 32'(r_s1_idx) < NET_DEPTH;
  assign w_host_oor    = 32'(host_rd_addr) >= NET_DEPTH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    rd           = 1'b0;
    busy         = 1'b1;
    w_restart    = 1'b0;
    w_close      = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_init_addr == ADDR_W'(NET_DEPTH - 1)) w_next_state = ST_IDLE;
      end
      ST_IDLE: begin
        busy = 1'b0;
        rd   = !empty;
        if (go || r_go_pend) begin
          w_restart    = 1'b1;
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        rd = !empty;
        if (go)        w_restart    = 1'b1;
        else if (done) w_next_state = ST_FLUSH;
      end
      ST_FLUSH: begin
        rd = !empty;
        if (go) begin
          w_restart    = 1'b1;
          w_next_state = ST_DRAIN;
        end else if (empty && !r_s1_valid && (r_run == RUN_W'(FLUSH_CYC - 1))) begin
          w_close      = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_addr <= '0;
      r_go_pend   <= 1'b0;
      r_run       <= '0;
    end else begin
      if (r_state == ST_INIT) r_init_addr <= r_init_addr + ADDR_W'(1);
      if (r_state == ST_INIT && go) r_go_pend <= 1'b1;
      else if (r_state == ST_IDLE)  r_go_pend <= 1'b0;
      if (r_state != ST_FLUSH) r_run <= '0;
      else if (rd)             r_run <= '0;
      else                     r_run <= r_run + RUN_W'(1);
    end
  end

  // Stage 1 captures the consumed record; stage 2 commits it one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid     <= 1'b0;
      r_s1_val       <= '0;
      r_s1_idx       <= '0;
      r_s1_time      <= '0;
      r_first        <= 1'b1;
      r_change_count <= '0;
      r_last_time    <= '0;
      r_iter_done    <= 1'b0;
      r_err_order    <= 1'b0;
      r_err_range    <= 1'b0;
      r_err_stray    <= 1'b0;
    end else begin
      r_iter_done <= w_close;
      r_s1_valid  <= rd;
      if (rd) begin
        r_s1_val  <= out_record[REC_VAL_MSB:REC_VAL_LSB];
        r_s1_idx  <= out_record[REC_IDX_MSB:REC_IDX_LSB];
        r_s1_time <= out_record[REC_TIME_MSB:REC_TIME_LSB];
      end
      if (w_restart) begin
        r_first        <= 1'b1;
        r_change_count <= '0;
        r_last_time    <= '0;
        r_err_order    <= 1'b0;
        r_err_range    <= 1'b0;
        r_err_stray    <= 1'b0;
      end else begin
        if (r_s1_valid) begin
          r_first <= 1'b0;
          if (!w_s1_in_range) begin
            r_err_range <= 1'b1;
          end else begin
            if (r_change_count != '1) r_change_count <= r_change_count + CNT_W'(1);
            r_last_time <= r_s1_time;
          end
          if (!r_first && (r_s1_time < r_last_time)) r_err_order <= 1'b1;
        end
        if (rd && r_state == ST_IDLE) r_err_stray <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_rd_oor <= 1'b0;
    else if (host_rd_en) r_rd_oor <= w_host_oor;
  end

  assign w_ram_we    = (r_state == ST_INIT) || (r_s1_valid && w_s1_in_range);
  assign w_ram_waddr = (r_state == ST_INIT) ? r_init_addr : r_s1_idx[ADDR_W-1:0];
  assign w_ram_wdata = (r_state == ST_INIT) ? VAL_X : r_s1_val;

  drain_shadow_ram #(
    .DEPTH  (NET_DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (2)
  ) u_shadow (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_ram_we),
    .waddr (w_ram_waddr),
    .wdata (w_ram_wdata),
    .re    (host_rd_en),
    .raddr (host_rd_addr[ADDR_W-1:0]),
    .rdata (w_ram_rdata)
  );

  assign host_rd_data = r_rd_oor ? VAL_X : w_ram_rdata;
  assign change_count = r_change_count;
  assign last_time    = r_last_time;
  assign iter_done    = r_iter_done;
  assign err_order    = r_err_order;
  assign err_range    = r_err_range;
  assign err_stray    = r_err_stray;

endmodule
`default_nettype wire

// File: tb/tb_turbosim_event_drain.sv
`default_nettype none
// tb_turbosim_event_drain: directed and randomized records checked against a
// record-level model of counts, timestamps, error flags and the net shadow.
module tb_turbosim_event_drain;

  localparam int NET_DEPTH = 512;

  logic        clk = 1'b0, rst_n = 1'b0, empty = 1'b1, go = 1'b0, done = 1'b0;
  logic        host_rd_en = 1'b0;
  logic [31:0] out_record = '0;
  logic [13:0] host_rd_addr = '0;
  logic        rd, iter_done, busy, err_order, err_range, err_stray;
  logic [1:0]  host_rd_data;
  logic [15:0] change_count, last_time;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0]  m_shadow [NET_DEPTH];
  int unsigned m_count, m_last;
  bit          m_first, m_order, m_range, m_stray, m_idle;

  turbosim_event_drain dut (
    .clk(clk), .rst_n(rst_n), .empty(empty), .out_record(out_record), .rd(rd),
    .go(go), .done(done), .host_rd_en(host_rd_en), .host_rd_addr(host_rd_addr),
    .host_rd_data(host_rd_data), .change_count(change_count), .last_time(last_time),
    .iter_done(iter_done), .busy(busy), .err_order(err_order), .err_range(err_range),
    .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_sweep();
    for (int i = 0; i < NET_DEPTH; i++) m_shadow[i] = 2'b10;
  endtask

  task automatic model_go();
    m_count = 0; m_last = 0; m_first = 1;
    m_order = 0; m_range = 0; m_stray = 0; m_idle = 0;
  endtask

  task automatic model_apply(input logic [31:0] rec);
    int unsigned idx, t;
    idx = rec[29:16];
    t   = rec[15:0];
    if (m_idle) m_stray = 1;
    if (!m_first && t < m_last) m_order = 1;
    m_first = 0;
    if (idx >= NET_DEPTH) m_range = 1;
    else begin
      m_shadow[idx] = rec[31:30];
      if (m_count < 65535) m_count++;
      m_last = t;
    end
  endtask

  task automatic push(input logic [31:0] rec, input bit with_go);
    empty = 1'b0; out_record = rec; go = with_go;
    tick();
    empty = 1'b1; go = 1'b0;
    if (with_go) model_go();
    model_apply(rec);
  endtask

  task automatic start_iter();
    go = 1'b1;
    tick();
    go = 1'b0;
    model_go();
  endtask

  task automatic host_read(input int addr, output logic [1:0] data);
    host_rd_en = 1'b1; host_rd_addr = 14'(addr);
    tick();
    host_rd_en = 1'b0;
    data = host_rd_data;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_count"}, 32'(change_count), m_count);
    check({tag, "_last_time"}, 32'(last_time), m_last);
    check({tag, "_err_order"}, 32'(err_order), 32'(m_order));
    check({tag, "_err_range"}, 32'(err_range), 32'(m_range));
    check({tag, "_err_stray"}, 32'(err_stray), 32'(m_stray));
  endtask

  task automatic finish_iter(input string tag);
    int n;
    done = 1'b1;
    tick();
    n = 0;
    while (!iter_done && n < 40) begin tick(); n++; end
    check({tag, "_iter_done_latency"}, n, 4);
    check({tag, "_idle_busy"}, 32'(busy), 0);
    m_idle = 1;
    done = 1'b0;
    tick();
    check({tag, "_iter_done_pulse"}, 32'(iter_done), 0);
  endtask

  task automatic wait_sweep(input string tag);
    int n;
    bit rd_seen;
    n = 0; rd_seen = 0;
    while (busy && n < 1000) begin
      tick(); n++;
      if (rd) rd_seen = 1;
      if (n == 10) empty = 1'b1;
    end
    check({tag, "_init_cycles"}, n, NET_DEPTH);
    check({tag, "_init_rd"}, 32'(rd_seen), 0);
    model_sweep();
  endtask

  initial begin
    logic [1:0]  rv;
    logic [31:0] rec;
    int          n, nrec, tprev, idx;
    int          idx_q[$];

    // Reset and initial sweep, with records waiting in the FIFO.
    empty = 1'b0; out_record = {2'b01, 14'd3, 16'd1};
    repeat (3) tick();
    check("rst_rd", 32'(rd), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_count", 32'(change_count), 0);
    check("rst_last_time", 32'(last_time), 0);
    check("rst_iter_done", 32'(iter_done), 0);
    check("rst_errs", {29'd0, err_order, err_range, err_stray}, 0);
    check("rst_host_data", 32'(host_rd_data), 0);
    rst_n = 1'b1;
    wait_sweep("s1");
    m_idle = 1; m_first = 1; m_count = 0; m_last = 0;
    host_read(0, rv);   check("sweep_addr0", 32'(rv), 2);
    host_read(17, rv);  check("sweep_addr17", 32'(rv), 2);
    host_read(511, rv); check("sweep_addr511", 32'(rv), 2);

    // Basic iteration.
    start_iter();
    push({2'b01, 14'd5, 16'd10}, 0);
    push({2'b00, 14'd7, 16'd20}, 0);
    push({2'b11, 14'd5, 16'd30}, 0);
    finish_iter("basic");
    check_model("basic");
    check("basic_count_abs", 32'(change_count), 3);
    check("basic_last_abs", 32'(last_time), 30);
    host_read(5, rv); check("basic_shadow5", 32'(rv), 32'(2'b11));
    host_read(7, rv); check("basic_shadow7", 32'(rv), 32'(2'b00));

    // Time going backwards.
    start_iter();
    push({2'b01, 14'd9, 16'd40}, 0);
    push({2'b00, 14'd9, 16'd25}, 0);
    finish_iter("order");
    check_model("order");
    check("order_flag_abs", 32'(err_order), 1);
    start_iter();
    check("order_cleared_by_go", 32'(err_order), 0);

    // Out-of-range index aliasing onto 88 must leave the shadow alone.
    push({2'b01, 14'd600, 16'd50}, 0);
    tick();
    check_model("range");
    check("range_flag_abs", 32'(err_range), 1);
    check("range_count_abs", 32'(change_count), 0);
    host_read(88, rv); check("range_shadow88", 32'(rv), 32'(m_shadow[88]));

    // Record arriving during flush restarts the empty run.
    done = 1'b1;
    tick(); tick(); tick();
    push({2'b11, 14'd12, 16'd60}, 0);
    n = 0;
    while (!iter_done && n < 40) begin tick(); n++; end
    check("flush_restart_latency", n, 4);
    m_idle = 1;
    done = 1'b0;
    tick();
    check_model("flush");
    push({2'b00, 14'd13, 16'd70}, 0);
    tick();
    check_model("stray");
    check("stray_flag_abs", 32'(err_stray), 1);

    // Randomized iterations, some restarted mid-drain by go with a record.
    for (int it = 0; it < 6; it++) begin
      start_iter();
      idx_q.delete();
      nrec  = $urandom_range(3, 12);
      tprev = $urandom_range(0, 100);
      for (int k = 0; k < nrec; k++) begin
        idx = ($urandom_range(0, 7) == 0) ? $urandom_range(NET_DEPTH, 16383)
                                          : $urandom_range(0, NET_DEPTH - 1);
        tprev = ($urandom_range(0, 5) == 0) ? $urandom_range(0, tprev)
                                            : tprev + $urandom_range(0, 40);
        rec = {2'($urandom_range(0, 3)), 14'(idx), 16'(tprev)};
        push(rec, (it % 2 == 1) && (k == nrec / 2));
        if (idx < NET_DEPTH) idx_q.push_back(idx);
        repeat ($urandom_range(0, 2)) tick();
      end
      finish_iter($sformatf("rand%0d", it));
      check_model($sformatf("rand%0d", it));
      for (int j = 0; j < idx_q.size() && j < 3; j++) begin
        host_read(idx_q[j], rv);
        check($sformatf("rand%0d_shadow%0d", it, idx_q[j]), 32'(rv), 32'(m_shadow[idx_q[j]]));
      end
    end

    // Reset in the middle of a drain with nine records counted.
    start_iter();
    for (int k = 0; k < 9; k++) push({2'b01, 14'(k + 1), 16'(100 + k)}, 0);
    tick();
    check("mid_count_before_rst", 32'(change_count), 9);
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(change_count), 0);
    check("mid_rst_busy", 32'(busy), 1);
    check("mid_rst_host_data", 32'(host_rd_data), 0);
    check("mid_rst_last_time", 32'(last_time), 0);
    tick();
    rst_n = 1'b1;
    wait_sweep("s6");
    m_idle = 1; m_first = 1; m_count = 0; m_last = 0;
    host_read(5, rv); check("resweep_addr5", 32'(rv), 2);

    // Host read colliding with the stage-2 write of the same net.
    start_iter();
    empty = 1'b0; out_record = {2'b01, 14'd33, 16'd5};
    tick();
    empty = 1'b1;
    model_apply(out_record);
    host_rd_en = 1'b1; host_rd_addr = 14'd33;
    tick();
    host_rd_en = 1'b0;
    check("fwd_same_cycle", 32'(host_rd_data), 32'(2'b01));
    finish_iter("fwd");
    check_model("fwd");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
